// File: rtl/ball_physics_pkg.sv
// ball_pkg: shared state codes, fixed-point formats and default geometry for the ball engine
// Contents:
//   ST_*     FSM state codes (2-bit)
//   POS_W    signed Q11.4 position width; VEL_W signed Q8.4 velocity width; FRAC fraction bits
//   *_DEF    default launch point and playfield limits in pixels
package ball_pkg;

    localparam int POS_W = 15;
    localparam int VEL_W = 12;
    localparam int FRAC  = 4;

    localparam int X0_DEF      = 10;
    localparam int Y0_DEF      = 300;
    localparam int FLOOR_Y_DEF = 460;
    localparam int X_MAX_DEF   = 639;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_FLIGHT = 2'd1;
    localparam state_t ST_LANDED = 2'd2;

    typedef logic signed [POS_W-1:0] pos_t;
    typedef logic signed [VEL_W-1:0] vel_t;

    function automatic pos_t to_pos(input int pix);
        return pos_t'(pix << FRAC);
    endfunction

endpackage

// File: rtl/ball_physics_frame_tick_gen.sv
// frame_tick_gen: turns each rising edge of vsync into a one-cycle frame tick
// Ports:
//   CLK25MHZ  pixel clock
//   reset     asynchronous, active-high
//   i_vsync   vertical sync, active-high
//   o_tick    one-cycle pulse on the cycle after a detected vsync rise
module frame_tick_gen (
    input  logic CLK25MHZ,
    input  logic reset,
    input  logic i_vsync,
    output logic o_tick
);

    logic       r_vs;
    logic       r_vs_d;
    logic       r_tick;
    logic [1:0] r_fill;

    // vsync is produced on the same pixel clock, so one sample stage suffices.
    // r_fill blocks edge detection until both samples hold real post-reset values,
    // so a vsync already high at reset release is not mistaken for a new frame.
    always_ff @(posedge CLK25MHZ or posedge reset) begin
        if (reset) begin
            r_vs   <= 1'b0;
            r_vs_d <= 1'b0;
            r_fill <= 2'b00;
            r_tick <= 1'b0;
        end else begin
            r_vs   <= i_vsync;
            r_vs_d <= r_vs;
            r_fill <= {r_fill[0], 1'b1};
            r_tick <= r_vs & ~r_vs_d & r_fill[1];
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/ball_physics.sv
// ball_physics: per-frame projectile motion of a ball with floor/side landing and timed rest
// Ports:
//   CLK25MHZ, reset      pixel clock, asynchronous active-high reset
//   vsync                vertical sync; motion advances once per frame
//   launch               shot request, honoured only in IDLE
//   vx0, vy0             signed Q4.4 launch velocity, px/frame (negative vy is upward)
//   ball_x, ball_y       ball position in pixels for the pixel generator
//   in_flight, landed    FLIGHT / LANDED state flags
module ball_physics
    import ball_pkg::*;
#(
    parameter int X0          = X0_DEF,
    parameter int Y0          = Y0_DEF,
    parameter int GRAVITY     = 1,
    parameter int FLOOR_Y     = FLOOR_Y_DEF,
    parameter int X_MAX       = X_MAX_DEF,
    parameter int REST_FRAMES = 60
) (
    input  logic              CLK25MHZ,
    input  logic              reset,
    input  logic              vsync,
    input  logic              launch,
    input  logic signed [7:0] vx0,
    input  logic signed [7:0] vy0,
    output logic [9:0]        ball_x,
    output logic [9:0]        ball_y,
    output logic              in_flight,
    output logic              landed
);

    localparam pos_t P_X0    = to_pos(X0);
    localparam pos_t P_Y0    = to_pos(Y0);
    localparam pos_t P_FLOOR = to_pos(FLOOR_Y);
    localparam pos_t P_XMAX  = to_pos(X_MAX);
    localparam pos_t P_XLIM  = to_pos(X_MAX + 1);
    localparam int   VEL_MAX = 2 ** (VEL_W - 1) - 1;

    state_t                r_state;
    pos_t                  r_px;
    pos_t                  r_py;
    vel_t                  r_vx;
    vel_t                  r_vy;
    logic [15:0]           r_cnt;
    pos_t                  w_npx;
    pos_t                  w_npy;
    logic signed [VEL_W:0] w_vy_sum;
    vel_t                  w_vy_next;
    logic                  w_tick;
    logic                  w_floor;
    logic                  w_left;
    logic                  w_right;
    logic                  w_land;

    frame_tick_gen u_tick (
        .CLK25MHZ (CLK25MHZ),
        .reset    (reset),
        .i_vsync  (vsync),
        .o_tick   (w_tick)
    );

    assign w_npx     = r_px + pos_t'(r_vx);
    assign w_npy     = r_py + pos_t'(r_vy);
    // One guard bit so the gravity add can be saturated instead of wrapping.
    assign w_vy_sum  = (VEL_W + 1)'(r_vy) + (VEL_W + 1)'(GRAVITY);
    assign w_vy_next = (w_vy_sum > VEL_MAX) ? vel_t'(VEL_MAX) : vel_t'(w_vy_sum);
    assign w_floor   = w_npy >= P_FLOOR;
    assign w_left    = w_npx[POS_W-1];
    assign w_right   = w_npx >= P_XLIM;
    assign w_land    = w_floor | w_left | w_right;

    always_ff @(posedge CLK25MHZ or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_px    <= P_X0;
            r_py    <= P_Y0;
            r_vx    <= '0;
            r_vy    <= '0;
            r_cnt   <= '0;
        end else if (r_state == ST_IDLE) begin
            // A launch on a tick cycle only loads; the first move waits for the next tick.
            if (launch) begin
                r_vx    <= vel_t'(vx0);
                r_vy    <= vel_t'(vy0);
                r_state <= ST_FLIGHT;
            end
        end else if (r_state == ST_FLIGHT) begin
            if (w_tick) begin
                r_px    <= w_left ? '0 : (w_right ? P_XMAX : w_npx);
                r_py    <= w_floor ? P_FLOOR : w_npy;
                r_vx    <= w_land ? '0 : r_vx;
                r_vy    <= w_land ? '0 : w_vy_next;
                r_state <= w_land ? ST_LANDED : ST_FLIGHT;
            end
        end else if (w_tick) begin
            // The tick that finds the counter at REST_FRAMES-1 ends the rest period.
            if (r_cnt == 16'(REST_FRAMES - 1)) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_px    <= P_X0;
                r_py    <= P_Y0;
            end else begin
                r_cnt   <= r_cnt + 16'd1;
            end
        end
    end

    // The ball may leave through the top; report row 0 while it is above the screen.
    assign ball_x    = r_px[POS_W-1] ? '0 : r_px[FRAC+9:FRAC];
    assign ball_y    = r_py[POS_W-1] ? '0 : r_py[FRAC+9:FRAC];
    assign in_flight = r_state == ST_FLIGHT;
    assign landed    = r_state == ST_LANDED;

endmodule

// File: doc/ball_physics.md
BALL_PHYSICS -- requirements
Module: ball_physics

Interface
REQ-001 Parameter X0, default 10, launch/rest x position in pixels.
REQ-002 Parameter Y0, default 300, launch/rest y position in pixels.
REQ-003 Parameter GRAVITY, default 1, per-frame increment of vy in Q8.4 (1/16 px/frame²).
REQ-004 Parameter FLOOR_Y, default 460, floor y in pixels; y grows downward.
REQ-005 Parameter X_MAX, default 639, rightmost legal x in pixels.
REQ-006 Parameter REST_FRAMES, default 60, frames held in LANDED before return to IDLE.
REQ-007 CLK25MHZ  input  1  pixel clock; all state on its rising edge.
REQ-008 reset  input  1  asynchronous, active-high.
REQ-009 vsync  input  1  vertical sync from the sync generator, active-high during the sync pulse.
REQ-010 launch  input  1  level, sampled per clock; requests a shot.
REQ-011 vx0  input  8  signed Q4.4 initial x velocity, px/frame.
REQ-012 vy0  input  8  signed Q4.4 initial y velocity, px/frame; negative is upward.
REQ-013 ball_x  output  10  ball x in pixels, registered.
REQ-014 ball_y  output  10  ball y in pixels, registered.
REQ-015 in_flight  output  1  high in FLIGHT.
REQ-016 landed  output  1  high in LANDED.

Function
REQ-017 Frame tick is a one-cycle pulse on the cycle after a detected rising edge of vsync; all motion advances only on frame ticks.
REQ-018 States: IDLE, FLIGHT, LANDED; encoding 2 bits.
REQ-019 IDLE: pos = (X0,Y0) integer, fraction 0; launch=1 loads vx=sign-extend(vx0), vy=sign-extend(vy0) to 12-bit Q8.4 and enters FLIGHT next cycle.
REQ-020 Launch coincident with a frame tick in IDLE: load wins; first motion occurs on the next frame tick.
REQ-021 FLIGHT, per frame tick: px += vx; py += vy; then vy += GRAVITY, saturating at +2047.
REQ-022 Position registers are 15-bit signed Q11.4; ball_x/ball_y = bits [13:4] of px/py.
REQ-023 ball_x/ball_y update exactly 1 clock after the frame tick (no combinational path from inputs).
REQ-024 Floor: if new py integer >= FLOOR_Y, py is clamped to FLOOR_Y (fraction 0), vx,vy cleared, state -> LANDED.
REQ-025 Side exit: if new px < 0 or integer > X_MAX, px is clamped to 0 or X_MAX, state -> LANDED; floor and side on same tick both clamp.
REQ-026 Upward exit above row 0 is allowed; ball_y reports 0 while py < 0.
REQ-027 LANDED: frame counter counts frame ticks from 0; at REST_FRAMES-1 state -> IDLE and position reloads X0,Y0.
REQ-028 launch ignored in FLIGHT and LANDED; no queuing.
REQ-029 vx0/vy0 sampled only on the load cycle; later changes have no effect mid-flight.

Reset
REQ-030 reset forces state IDLE, px=X0, py=Y0, vx=vy=0, frame counter 0, vsync edge register 0.
REQ-031 Reset values: ball_x=X0, ball_y=Y0, in_flight=0, landed=0.
REQ-032 Reset mid-FLIGHT or mid-LANDED aborts immediately; no frame tick is generated from the first vsync sample after release.

Structure
REQ-033 Shared package ball_pkg holds state enumeration, Q-format widths (POS_W=15, VEL_W=12, FRAC=4) and default X0/Y0/FLOOR_Y/X_MAX.
REQ-034 One sub-module frame_tick_gen: vsync synchroniser/edge detector producing the frame tick.
REQ-035 ball_x/ball_y feed the pixel generator's ball coordinate inputs directly.

Verification
REQ-036 Reset held, vsync toggling -> ball_x=10, ball_y=300, in_flight=0, landed=0.
REQ-037 GRAVITY=16, vx0=32, vy0=-64, launch then 3 frames -> (x,y) = (12,296), (14,293), (16,291).
REQ-038 Launch and frame tick same cycle -> position unchanged at that tick, first move on next tick.
REQ-039 vx0=0, vy0=+127 -> ball_y reaches exactly 460, landed=1; after 60 frame ticks IDLE with (10,300).
REQ-040 vx0=-16, vy0=0, GRAVITY=0 -> x decreases 1/frame; tick making x<0 gives ball_x=0, landed=1.
REQ-041 Assert reset mid-FLIGHT -> next clock (10,300), IDLE; launch during FLIGHT -> no reload.
